cpu_trace_checker: RTL

Parametrised character-stream checker for CPU trace lines, the successor to the fixed-format trace checker in the p1-p2 test infrastructure. It consumes one ASCII character per accepted cycle and recognises register-write and memory-write trace lines. For each complete line it reports format and error flags through registered outputs. It adds a stall-capable input handshake, written-data capture, a `$0`-write check, configurable legal ranges, and line/error counters.

---
 rtl/cpu_trace_checker.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_trace_checker.sv
// Character-stream checker for CPU register-write and memory-write trace lines.
// Parses one ASCII character per accepted cycle and reports format/error flags per completed line.
module cpu_trace_checker #(
   parameter int          TIME_DIGITS = 4,
   parameter int          GRF_DIGITS  = 2,
   parameter int          GRF_MAX     = 31,
   parameter logic [31:0] PC_LO       = 32'h0000_3000,
   parameter logic [31:0] PC_HI       = 32'h0000_4fff,
   parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
   parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       char,
   input  logic             char_valid,
   input  logic [15:0]      freq,
   output logic [1:0]       format_type,
   output logic [4:0]       error_code,
   output logic             line_done,
   output logic [31:0]      pc_out,
   output logic [31:0]      data_out,
   output logic [CNT_W-1:0] line_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [3:0] {
      S_IDLE, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_GRF,
      S_MEM, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_DONE
   } state_t;

   localparam logic [7:0] CH_CARET  = 8'h5e;
   localparam logic [7:0] CH_AT     = 8'h40;
   localparam logic [7:0] CH_COLON  = 8'h3a;
   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_STAR   = 8'h2a;
   localparam logic [7:0] CH_LT     = 8'h3c;
   localparam logic [7:0] CH_EQ     = 8'h3d;
   localparam logic [7:0] CH_HASH   = 8'h23;

   localparam logic [3:0] T_DIG     = 4'(TIME_DIGITS);
   localparam logic [3:0] G_DIG     = 4'(GRF_DIGITS);
   localparam logic [3:0] HEX_DIG   = 4'd8;
   localparam logic [6:0] GRF_MAX_C = 7'(GRF_MAX);

   state_t             state_reg, state_next;
   logic [3:0]         cnt_reg, cnt_next;
   logic [15:0]        time_reg, time_next;
   logic [31:0]        pc_reg, pc_next;
   logic [6:0]         grf_reg, grf_next;
   logic [31:0]        addr_reg, addr_next;
   logic [31:0]        data_reg, data_next;
   logic               mem_reg, mem_next;
   logic [1:0]         format_reg, format_next;
   logic [4:0]         error_reg, error_next;
   logic               line_done_reg, line_done_next;
   logic [31:0]        pc_out_reg, pc_out_next;
   logic [31:0]        data_out_reg, data_out_next;
   logic [CNT_W-1:0]   line_count_reg, line_count_next;
   logic [CNT_W-1:0]   err_count_reg, err_count_next;

   logic               is_dec, is_lhex, is_hex;
   logic [3:0]         nibble;
   logic [15:0]        time_mask;
   logic [4:0]         err_vec;

   // Unsigned offset compare avoids constant comparisons when a bound is zero.
   function automatic logic in_range(input logic [31:0] v, input logic [31:0] lo,
                                     input logic [31:0] hi);
      return (v - lo) <= (hi - lo);
   endfunction

   assign is_dec    = (char >= 8'h30) && (char <= 8'h39);
   assign is_lhex   = (char >= 8'h61) && (char <= 8'h66);
   assign is_hex    = is_dec || is_lhex;
   assign nibble    = is_lhex ? (char[3:0] + 4'd9) : char[3:0];
   assign time_mask = (freq >> 1) - 16'd1;

   always_comb begin
      err_vec    = 5'b00000;
      err_vec[0] = |(time_reg & time_mask);
      err_vec[1] = !in_range(pc_reg, PC_LO, PC_HI) || (pc_reg[1:0] != 2'b00);
      err_vec[2] = mem_reg && (!in_range(addr_reg, ADDR_LO, ADDR_HI) ||
                               (addr_reg[1:0] != 2'b00));
      err_vec[3] = !mem_reg && (grf_reg > GRF_MAX_C);
      err_vec[4] = !mem_reg && (grf_reg == 7'd0) && (data_reg != 32'd0);
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      time_next       = time_reg;
      pc_next         = pc_reg;
      grf_next        = grf_reg;
      addr_next       = addr_reg;
      data_next       = data_reg;
      mem_next        = mem_reg;
      format_next     = format_reg;
      error_next      = error_reg;
      line_done_next  = 1'b0;
      pc_out_next     = pc_out_reg;
      data_out_next   = data_out_reg;
      line_count_next = line_count_reg;
      err_count_next  = err_count_reg;

      if (char_valid) begin
         // Flags are only nonzero in DONE, so any accepted character clears them.
         format_next = 2'b00;
         error_next  = 5'b00000;
         if (char == CH_CARET) begin
            state_next = S_TIME;
            cnt_next   = 4'd0;
            time_next  = 16'd0;
            pc_next    = 32'd0;
            grf_next   = 7'd0;
            addr_next  = 32'd0;
            data_next  = 32'd0;
            mem_next   = 1'b0;
         end else begin
            state_next = S_IDLE;
            case (state_reg)
               S_TIME: begin
                  if (is_dec && (cnt_reg < T_DIG)) begin
                     time_next  = time_reg * 16'd10 + {12'd0, char[3:0]};
                     cnt_next   = cnt_reg + 4'd1;
                     state_next = S_TIME;
                  end else if ((char == CH_AT) && (cnt_reg != 4'd0)) begin
                     cnt_next   = 4'd0;
                     state_next = S_AT;
                  end
               end
               S_AT, S_PC: begin
                  if (is_hex && (cnt_reg < HEX_DIG)) begin
                     pc_next    = {pc_reg[27:0], nibble};
                     cnt_next   = cnt_reg + 4'd1;
                     state_next = S_PC;
                  end else if ((char == CH_COLON) && (cnt_reg == HEX_DIG)) begin
                     state_next = S_COLON;
                  end
               end
               S_COLON, S_SP1: begin
                  if (char == CH_SPACE) begin
                     state_next = S_SP1;
                  end else if (char == CH_DOLLAR) begin
                     cnt_next   = 4'd0;
                     mem_next   = 1'b0;
                     state_next = S_GRF;
                  end else if (char == CH_STAR) begin
                     cnt_next   = 4'd0;
                     mem_next   = 1'b1;
                     state_next = S_MEM;
                  end
               end
               S_GRF: begin
                  // Spaces between '$' and the first register digit are tolerated.
                  if (is_dec && (cnt_reg < G_DIG)) begin
                     grf_next   = grf_reg * 7'd10 + {3'd0, char[3:0]};
                     cnt_next   = cnt_reg + 4'd1;
                     state_next = S_GRF;
                  end else if ((char == CH_SPACE) && (cnt_reg == 4'd0)) begin
                     state_next = S_GRF;
                  end else if ((char == CH_SPACE) && (cnt_reg != 4'd0)) begin
                     state_next = S_SP2;
                  end else if ((char == CH_LT) && (cnt_reg != 4'd0)) begin
                     state_next = S_LT;
                  end
               end
               S_MEM: begin
                  if (is_hex && (cnt_reg < HEX_DIG)) begin
                     addr_next  = {addr_reg[27:0], nibble};
                     cnt_next   = cnt_reg + 4'd1;
                     state_next = S_MEM;
                  end else if ((char == CH_SPACE) && (cnt_reg == HEX_DIG)) begin
                     state_next = S_SP2;
                  end else if ((char == CH_LT) && (cnt_reg == HEX_DIG)) begin
                     state_next = S_LT;
                  end
               end
               S_SP2: begin
                  if (char == CH_SPACE) begin
                     state_next = S_SP2;
                  end else if (char == CH_LT) begin
                     state_next = S_LT;
                  end
               end
               S_LT: begin
                  if (char == CH_EQ) begin
                     state_next = S_EQ;
                  end
               end
               S_EQ, S_SP3: begin
                  if (char == CH_SPACE) begin
                     state_next = S_SP3;
                  end else if (is_hex) begin
                     data_next  = {28'd0, nibble};
                     cnt_next   = 4'd1;
                     state_next = S_DATA;
                  end
               end
               S_DATA: begin
                  if (is_hex && (cnt_reg < HEX_DIG)) begin
                     data_next  = {data_reg[27:0], nibble};
                     cnt_next   = cnt_reg + 4'd1;
                     state_next = S_DATA;
                  end else if ((char == CH_HASH) && (cnt_reg == HEX_DIG)) begin
                     state_next     = S_DONE;
                     format_next    = mem_reg ? 2'b10 : 2'b01;
                     error_next     = err_vec;
                     pc_out_next    = pc_reg;
                     data_out_next  = data_reg;
                     line_done_next = 1'b1;
                     if (line_count_reg != {CNT_W{1'b1}}) begin
                        line_count_next = line_count_reg + CNT_W'(1);
                     end
                     if ((err_vec != 5'b00000) && (err_count_reg != {CNT_W{1'b1}})) begin
                        err_count_next = err_count_reg + CNT_W'(1);
                     end
                  end
               end
               default: begin
                  state_next = S_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= S_IDLE;
         cnt_reg        <= 4'd0;
         time_reg       <= 16'd0;
         pc_reg         <= 32'd0;
         grf_reg        <= 7'd0;
         addr_reg       <= 32'd0;
         data_reg       <= 32'd0;
         mem_reg        <= 1'b0;
         format_reg     <= 2'b00;
         error_reg      <= 5'b00000;
         line_done_reg  <= 1'b0;
         pc_out_reg     <= 32'd0;
         data_out_reg   <= 32'd0;
         line_count_reg <= '0;
         err_count_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         time_reg       <= time_next;
         pc_reg         <= pc_next;
         grf_reg        <= grf_next;
         addr_reg       <= addr_next;
         data_reg       <= data_next;
         mem_reg        <= mem_next;
         format_reg     <= format_next;
         error_reg      <= error_next;
         line_done_reg  <= line_done_next;
         pc_out_reg     <= pc_out_next;
         data_out_reg   <= data_out_next;
         line_count_reg <= line_count_next;
         err_count_reg  <= err_count_next;
      end
   end

   assign format_type = format_reg;
   assign error_code  = error_reg;
   assign line_done   = line_done_reg;
   assign pc_out      = pc_out_reg;
   assign data_out    = data_out_reg;
   assign line_count  = line_count_reg;
   assign err_count   = err_count_reg;

endmodule
